led_breather: RTL
=================

// Module: led_breather
// PURPOSE
//  Downstream consumer of the free-running 16-bit clock counter. Turns the counter value into a
//  "breathing" LED drive: a PWM whose duty ramps up, holds, ramps down and holds, forever.
//  Sits beside/in place of the plain blinker in tt_um_mrmola and drives one uo_out bit.
// PARAMETERS
//  CW          16  width of count_in (must match the counter output)
//  DUTY_W      8   duty/PWM-phase width; PWM phase = count_in[DUTY_W-1:0]; needs DUTY_W < CW
//  STEP_DIV    4   PWM periods per duty step (>=1)
//  HOLD_STEPS  32  duty steps spent in each hold state (0 = no hold)
// PORTS
//  clk         in   1       clock
//  rst         in   1       asynchronous reset, active-high
//  count_in    in   CW      current counter value
//  en          in   1       1 = breathe; 0 = force IDLE
//  pwm_out     out  1       LED drive, registered
//  duty        out  DUTY_W  current programmed duty, registered
//  state_o     out  3       current FSM state encoding
//  cycle_done  out  1       one-clk pulse when HOLD_LO finishes (one full breath)
// BEHAVIOUR
//  - Reset: pwm_out=0, duty=0, state=IDLE, cycle_done=0, tick prescaler=0, hold counter=0.
//  - Period tick: registered prev-phase; tick=1 for one clk when phase==0 && prev_phase!=0.
//    Counter stall -> no ticks; counter jump to 0 -> one tick. Step = every STEP_DIV-th tick.
//  - FSM (state_o): IDLE=0, RISE=1, HOLD_HI=2, FALL=3, HOLD_LO=4.
//    IDLE: en=1 -> RISE next clk, duty=0, prescaler cleared.
//    RISE: on step duty++; when duty reaches 2^DUTY_W-1 -> HOLD_HI (hold cnt=0).
//    HOLD_HI: on step hold cnt++; at HOLD_STEPS -> FALL. HOLD_STEPS=0 -> FALL on first step.
//    FALL: on step duty--; when duty reaches 0 -> HOLD_LO.
//    HOLD_LO: as HOLD_HI; on exit -> RISE and cycle_done=1 for that clk.
//  - duty saturates: never wraps past max or below 0.
//  - en=0 in any state: next clk IDLE, duty=0, pwm_out=0; counters cleared. Highest priority
//    after rst. en rising together with a tick: tick ignored, counting starts next tick.
//  - pwm_out registered: pwm_out <= (phase < eff_duty) && state!=IDLE; latency 1 clk from
//    count_in. duty=max gives (2^DUTY_W-1)/2^DUTY_W high; duty=0 gives constant low.
//  - rst mid-breath: outputs return to reset values immediately (async), resume IDLE.
// CONFIGURATION
//  LED_BREATHER_GAMMA_EN defined: eff_duty = (duty*duty) >> DUTY_W (2*DUTY_W-bit product,
//    upper DUTY_W bits) for perceptually linear fade. Undefined: eff_duty = duty.
//  duty output is always the linear value in both builds.
// STRUCTURE
//  breather_pkg: state enum (IDLE..HOLD_LO, 3-bit), state width constant, default
//    DUTY_W/HOLD_STEPS constants shared with the top.
//  Sub-module breather_tick_gen: phase edge detect + STEP_DIV prescaler, outputs step pulse.
//  FSM, duty register, hold counter, PWM compare in led_breather.
// TESTING (bench uses DUTY_W=4, STEP_DIV=1, HOLD_STEPS=2, count_in from a +1/clk counter)
//  - rst high, en=1 -> pwm_out=0, duty=0, state_o=0; release rst -> state_o=1 next clk.
//  - Run RISE: duty 0->15 in 15 steps (15*16 clks), then state_o=2; pwm high 15/16 clks at max.
//  - Full breath: cycle_done pulses once after 15+2+15+2=34 steps (544 clks) from RISE entry.
//  - en=0 mid-FALL at duty=7 -> next clk state_o=0, duty=0, pwm_out=0; en=1 -> restarts RISE.
//  - Freeze count_in for 100 clks in RISE -> duty unchanged, no tick; resumes on unfreeze.
//  - With LED_BREATHER_GAMMA_EN, duty=8 -> eff 4: pwm high 4 of 16 clks; without: 8 of 16.

Source files
------------

// File: rtl/breather_pkg.sv
// breather_pkg: FSM state encoding and default sizing shared by the LED breather blocks.
package breather_pkg;
   localparam int ST_W           = 3;
   localparam int DEF_CW         = 16;
   localparam int DEF_DUTY_W     = 8;
   localparam int DEF_STEP_DIV   = 4;
   localparam int DEF_HOLD_STEPS = 32;
   typedef enum logic [ST_W-1:0] {
      IDLE    = 3'd0,
      RISE    = 3'd1,
      HOLD_HI = 3'd2,
      FALL    = 3'd3,
      HOLD_LO = 3'd4
   } state_t;
endpackage

// File: rtl/breather_tick_gen.sv
// breather_tick_gen: detects PWM phase wrap to zero and divides those ticks into duty steps.
module breather_tick_gen #(
   parameter int PH_W     = 8,
   parameter int STEP_DIV = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [PH_W-1:0] phase,
   input  logic            clr,
   output logic            step
);
   localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(STEP_DIV - 1);
   logic [PH_W-1:0] prev_q, prev_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic            tick;
   always_comb begin
      prev_d  = phase;
      tick    = (phase == '0) && (prev_q != '0);
      step    = tick && !clr && (presc_q == LAST);
      presc_d = clr ? '0 : tick ? ((presc_q == LAST) ? '0 : presc_q + 1'b1) : presc_q;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q  <= '0;
         presc_q <= '0;
      end else begin
         prev_q  <= prev_d;
         presc_q <= presc_d;
      end
   end
endmodule

// File: rtl/led_breather.sv
// led_breather: breathing-LED PWM driven from a free-running counter.
// Define LED_BREATHER_GAMMA_EN to square the duty before the PWM compare.
module led_breather
   import breather_pkg::*;
#(
   parameter int CW         = DEF_CW,
   parameter int DUTY_W     = DEF_DUTY_W,
   parameter int STEP_DIV   = DEF_STEP_DIV,
   parameter int HOLD_STEPS = DEF_HOLD_STEPS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CW-1:0]     count_in,
   input  logic              en,
   output logic              pwm_out,
   output logic [DUTY_W-1:0] duty,
   output logic [ST_W-1:0]   state_o,
   output logic              cycle_done
);
   localparam int HW = $clog2(HOLD_STEPS + 2);
   localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_STEPS == 0) ? 0 : HOLD_STEPS - 1);
   localparam logic [DUTY_W-1:0] DMAX = '1;
   state_t            state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d, eff_duty, phase;
   logic [HW-1:0]     hold_q, hold_d;
   logic              pwm_q, pwm_d, done_q, done_d, step, hold_end, unused_hi;
   assign phase     = count_in[DUTY_W-1:0];
   assign unused_hi = ^count_in[CW-1:DUTY_W];
   breather_tick_gen #(.PH_W(DUTY_W), .STEP_DIV(STEP_DIV)) u_tick (
      .clk   (clk),
      .rst   (rst),
      .phase (phase),
      .clr   (!en || state_q == IDLE),
      .step  (step)
   );
`ifdef LED_BREATHER_GAMMA_EN
   logic [2*DUTY_W-1:0] duty_sq;
   assign duty_sq  = {{DUTY_W{1'b0}}, duty_q} * {{DUTY_W{1'b0}}, duty_q};
   assign eff_duty = duty_sq[2*DUTY_W-1:DUTY_W];
`else
   assign eff_duty = duty_q;
`endif
   always_comb begin
      state_d  = state_q;
      duty_d   = duty_q;
      hold_d   = hold_q;
      done_d   = 1'b0;
      hold_end = hold_q >= HOLD_LAST;
      if (!en) begin
         state_d = IDLE;
         duty_d  = '0;
         hold_d  = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               state_d = RISE;
               duty_d  = '0;
               hold_d  = '0;
            end
            RISE: if (step) begin
               duty_d = (duty_q == DMAX) ? DMAX : duty_q + 1'b1;
               if (duty_q >= DMAX - 1'b1) begin
                  state_d = HOLD_HI;
                  hold_d  = '0;
               end
            end
            HOLD_HI: if (step) begin
               hold_d  = hold_end ? '0 : hold_q + 1'b1;
               state_d = hold_end ? FALL : HOLD_HI;
            end
            FALL: if (step) begin
               duty_d = (duty_q == '0) ? '0 : duty_q - 1'b1;
               if (duty_q <= DUTY_W'(1)) begin
                  state_d = HOLD_LO;
                  hold_d  = '0;
               end
            end
            HOLD_LO: if (step) begin
               hold_d  = hold_end ? '0 : hold_q + 1'b1;
               state_d = hold_end ? RISE : HOLD_LO;
               done_d  = hold_end;
            end
            default: state_d = IDLE;
         endcase
      end
      // Uses the pre-update duty so the output lags count_in by exactly one clock.
      pwm_d = en && (state_q != IDLE) && (phase < eff_duty);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         duty_q  <= '0;
         hold_q  <= '0;
         pwm_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         hold_q  <= hold_d;
         pwm_q   <= pwm_d;
         done_q  <= done_d;
      end
   end
   assign pwm_out    = pwm_q;
   assign duty       = duty_q;
   assign state_o    = state_q;
   assign cycle_done = done_q;
endmodule
